// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock supervisor: pulses the PLL reset, filters the synchronised lock,
// holds the core in reset until lock is stable, and counts relock/timeout events.
`timescale 1ns/1ps
module pll_lock_ctrl #(
   parameter int RST_PULSE_CYC    = 16,
   parameter int LOCK_FILT_CYC    = 64,
   parameter int HOLD_CYC         = 256,
   parameter int LOCK_TIMEOUT_CYC = 50000,
   parameter int CNT_W            = 16
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   input  logic       force_relock,
   output logic       pll_rst,
   output logic       core_rst,
   output logic       pll_ready,
   output logic [7:0] relock_cnt,
   output logic [7:0] timeout_cnt
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      FILTER    = 3'd2,
      HOLD      = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] phase_cnt;
   logic [CNT_W-1:0] to_cnt;
   logic             lock_sync_p0;
   logic             lock_sync_p1;
   logic             locked_s;
   logic             to_hit;
   logic             relock_evt;
   logic             timeout_evt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign locked_s = lock_sync_p1;
   assign to_hit   = (to_cnt == TO_LAST);

   always_comb begin
      nxt         = state;
      relock_evt  = 1'b0;
      timeout_evt = 1'b0;
      case (state)
         RESET_PLL: begin
            if (phase_cnt == RST_LAST) nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (to_hit) begin
               nxt         = RESET_PLL;
               timeout_evt = 1'b1;
            end else if (locked_s) begin
               nxt = FILTER;
            end
         end
         FILTER: begin
            // A filter that completes on the timeout cycle still counts as a lock.
            if (locked_s && (phase_cnt == FILT_LAST)) begin
               nxt = HOLD;
            end else if (to_hit) begin
               nxt         = RESET_PLL;
               timeout_evt = 1'b1;
            end else if (!locked_s) begin
               nxt = WAIT_LOCK;
            end
         end
         HOLD: begin
            if (!locked_s) begin
               nxt        = RESET_PLL;
               relock_evt = 1'b1;
            end else if (phase_cnt == HOLD_LAST) begin
               nxt = RUN;
            end
         end
         RUN: begin
            if (!locked_s) begin
               nxt        = RESET_PLL;
               relock_evt = 1'b1;
            end
         end
         default: nxt = RESET_PLL;
      endcase
      if (force_relock && (state != RESET_PLL)) begin
         nxt         = RESET_PLL;
         relock_evt  = 1'b0;
         timeout_evt = 1'b0;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state        <= RESET_PLL;
         phase_cnt    <= '0;
         to_cnt       <= '0;
         lock_sync_p0 <= 1'b0;
         lock_sync_p1 <= 1'b0;
         pll_rst      <= 1'b1;
         core_rst     <= 1'b1;
         pll_ready    <= 1'b0;
         relock_cnt   <= 8'd0;
         timeout_cnt  <= 8'd0;
      end else begin
         // Synchroniser stage boundary: locked -> p0 -> p1 (locked_s)
         lock_sync_p0 <= locked;
         lock_sync_p1 <= lock_sync_p0;

         state     <= nxt;
         phase_cnt <= (nxt != state) ? '0 : phase_cnt + CNT_W'(1);

         if (state == RESET_PLL)
            to_cnt <= '0;
         else if ((state == WAIT_LOCK) || (state == FILTER))
            to_cnt <= to_cnt + CNT_W'(1);

         if (relock_evt)  relock_cnt  <= sat_inc(relock_cnt);
         if (timeout_evt) timeout_cnt <= sat_inc(timeout_cnt);

         pll_rst   <= (nxt == RESET_PLL);
         core_rst  <= (nxt != RUN);
         pll_ready <= (nxt == RUN);
      end
   end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: expected output snapshots are queued against edge
// numbers as stimulus is applied and compared when that edge has occurred.
`timescale 1ns/1ps
module tb_pll_lock_ctrl;

   localparam int RST_P = 16;
   localparam int TO_P  = 250;
   localparam int P     = RST_P + TO_P;

   logic       refclk = 1'b0;
   logic       rst;
   logic       locked;
   logic       force_relock;
   logic       pll_rst;
   logic       core_rst;
   logic       pll_ready;
   logic [7:0] relock_cnt;
   logic [7:0] timeout_cnt;

   typedef struct {
      int         cyc;
      string      tag;
      logic       pr;
      logic       cr;
      logic       rdy;
      logic [7:0] rc;
      logic [7:0] tc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   pll_lock_ctrl #(
      .RST_PULSE_CYC(RST_P),
      .LOCK_FILT_CYC(64),
      .HOLD_CYC(256),
      .LOCK_TIMEOUT_CYC(TO_P),
      .CNT_W(16)
   ) dut (
      .refclk(refclk),
      .rst(rst),
      .locked(locked),
      .force_relock(force_relock),
      .pll_rst(pll_rst),
      .core_rst(core_rst),
      .pll_ready(pll_ready),
      .relock_cnt(relock_cnt),
      .timeout_cnt(timeout_cnt)
   );

   always #10 refclk = ~refclk;
   always @(posedge refclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int c, input string tag, input logic pr, input logic cr,
                       input logic rdy, input int rc, input int tc);
      exp_t e;
      e.cyc = c; e.tag = tag; e.pr = pr; e.cr = cr; e.rdy = rdy;
      e.rc = 8'(rc); e.tc = 8'(tc);
      sb.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge refclk);
   endtask

   always @(negedge refclk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            chk({sb[i].tag, "_pll_rst"},     32'(pll_rst),     32'(sb[i].pr));
            chk({sb[i].tag, "_core_rst"},    32'(core_rst),    32'(sb[i].cr));
            chk({sb[i].tag, "_pll_ready"},   32'(pll_ready),   32'(sb[i].rdy));
            chk({sb[i].tag, "_relock_cnt"},  32'(relock_cnt),  32'(sb[i].rc));
            chk({sb[i].tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'(sb[i].tc));
            sb.delete(i);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r, l1, d1, l2, n, f, g, r2;
      rst = 1'b1; locked = 1'b0; force_relock = 1'b0;
      repeat (3) @(negedge refclk);
      chk("rst_pll_rst",   32'(pll_rst),     32'd1);
      chk("rst_core_rst",  32'(core_rst),    32'd1);
      chk("rst_pll_ready", 32'(pll_ready),   32'd0);
      chk("rst_relock",    32'(relock_cnt),  32'd0);
      chk("rst_timeout",   32'(timeout_cnt), 32'd0);

      // Release reset: PLL reset pulse lasts 16 edges
      rst = 1'b0; r = cyc;
      push(r + 1,  "rel_e1",  1, 1, 0, 0, 0);
      push(r + 15, "rel_e15", 1, 1, 0, 0, 0);
      push(r + 16, "rel_e16", 0, 1, 0, 0, 0);

      // Lock 100 cycles after pll_rst falls; ready on edge 323
      wait_until(r + 116);
      locked = 1'b1; l1 = cyc + 1;
      push(l1 + 321, "lock_e322", 0, 1, 0, 0, 0);
      push(l1 + 322, "lock_e323", 0, 0, 1, 0, 0);
      wait_until(l1 + 330);

      // Lock loss in RUN: outputs and relock_cnt change on edge 3
      locked = 1'b0; d1 = cyc + 1;
      push(d1 + 1,  "loss_e2",  0, 0, 1, 0, 0);
      push(d1 + 2,  "loss_e3",  1, 1, 0, 1, 0);
      push(d1 + 17, "loss_e18", 1, 1, 0, 1, 0);
      push(d1 + 18, "loss_e19", 0, 1, 0, 1, 0);
      wait_until(d1 + 30);
      locked = 1'b1; l2 = cyc + 1;
      push(l2 + 321, "relock_e322", 0, 1, 0, 1, 0);
      push(l2 + 322, "relock_e323", 0, 0, 1, 1, 0);
      wait_until(l2 + 330);

      // force_relock in RUN with lock held: no count change
      force_relock = 1'b1; n = cyc + 1;
      push(n,       "frc_e1",   1, 1, 0, 1, 0);
      push(n + 15,  "frc_e16",  1, 1, 0, 1, 0);
      push(n + 16,  "frc_e17",  0, 1, 0, 1, 0);
      push(n + 80,  "frc_filt", 0, 1, 0, 1, 0);
      push(n + 336, "frc_hold", 0, 1, 0, 1, 0);
      push(n + 337, "frc_run",  0, 0, 1, 1, 0);
      @(negedge refclk); force_relock = 1'b0;
      wait_until(n + 340);

      // One-cycle lock glitch at filter count 40 forces a full refilter
      force_relock = 1'b1; f = cyc + 1;
      push(f + 122, "glt_filt",     0, 1, 0, 1, 0);
      push(f + 123, "glt_hold",     0, 1, 0, 1, 0);
      push(f + 337, "glt_no_early", 0, 1, 0, 1, 0);
      push(f + 378, "glt_pre_run",  0, 1, 0, 1, 0);
      push(f + 379, "glt_run",      0, 0, 1, 1, 0);
      @(negedge refclk); force_relock = 1'b0;
      wait_until(f + 55); locked = 1'b0;
      wait_until(f + 56); locked = 1'b1;
      wait_until(f + 385);

      // Asynchronous reset in HOLD clears outputs and counters immediately
      force_relock = 1'b1; g = cyc + 1;
      push(g + 99, "hold_pre", 0, 1, 0, 1, 0);
      @(negedge refclk); force_relock = 1'b0;
      wait_until(g + 100);
      #3 rst = 1'b1; locked = 1'b0;
      #1;
      chk("arst_pll_rst",   32'(pll_rst),     32'd1);
      chk("arst_core_rst",  32'(core_rst),    32'd1);
      chk("arst_pll_ready", 32'(pll_ready),   32'd0);
      chk("arst_relock",    32'(relock_cnt),  32'd0);
      chk("arst_timeout",   32'(timeout_cnt), 32'd0);
      repeat (2) @(negedge refclk);
      rst = 1'b0; r2 = cyc;

      // Timeouts with locked low; force_relock ignored in RESET_PLL; saturation at 255
      push(r2 + 16, "to_wait", 0, 1, 0, 0, 0);
      for (int k = 1; k <= 2; k++) begin
         push(r2 + k * P - 1, $sformatf("to%0d_pre", k), 0, 1, 0, 0, k - 1);
         push(r2 + k * P,     $sformatf("to%0d", k),     1, 1, 0, 0, k);
      end
      push(r2 + 255 * P - 1, "to255_pre", 0, 1, 0, 0, 254);
      push(r2 + 255 * P,     "to255",     1, 1, 0, 0, 255);
      push(r2 + 256 * P - 1, "to256_pre", 0, 1, 0, 0, 255);
      push(r2 + 256 * P,     "to256_sat", 1, 1, 0, 0, 255);
      wait_until(r2 + 4);
      force_relock = 1'b1;
      @(negedge refclk); force_relock = 1'b0;
      wait_until(r2 + 256 * P + 5);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Reset/lock supervisor for the core PLL, clocked from the stable 50 MHz reference clock. It is the controlling end of the PLL's reset/locked interface: it drives the PLL reset and qualifies the PLL lock indication. It holds the core in reset until lock has been stable for a programmable time, and re-initialises the PLL on loss of lock or lock timeout. It also counts relock and timeout events for the OSD status line.

## Interface
Parameters:
- RST_PULSE_CYC, 16: PLL reset pulse length in refclk cycles (≥2).
- LOCK_FILT_CYC, 64: consecutive cycles synchronised lock must stay high before it is accepted (≥2).
- HOLD_CYC, 256: cycles core_rst stays asserted after lock is accepted (≥2).
- LOCK_TIMEOUT_CYC, 50000: maximum cycles in WAIT_LOCK+FILTER before the PLL is reset again (1 ms at 50 MHz; > LOCK_FILT_CYC).
- CNT_W, 16: width of the shared phase counter. Every *_CYC value must be ≤ 2^CNT_W−1.

Ports:
- refclk  in  1  50 MHz reference clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- locked  in  1  PLL lock, asynchronous to refclk; passed through a 2-flop synchroniser to give locked_s.
- force_relock  in  1  single-cycle request to re-initialise the PLL (e.g. after reconfiguration).
- pll_rst  out  1  reset to the PLL.
- core_rst  out  1  core reset request; downstream logic synchronises it into the PLL output domain.
- pll_ready  out  1  high only in RUN.
- relock_cnt  out  8  count of lock losses in HOLD/RUN; saturates at 255.
- timeout_cnt  out  8  count of lock timeouts; saturates at 255.

## Operation
- Reset values while rst is high: state=RESET_PLL, pll_rst=1, core_rst=1, pll_ready=0, relock_cnt=0, timeout_cnt=0, phase counter=0, synchroniser flops=0.
- All outputs are registered. They are decoded from the next state, so they change on the same edge as the state.
- The phase counter clears on every state change and otherwise increments.
- RESET_PLL: pll_rst=1, core_rst=1.
  - Go to WAIT_LOCK after RST_PULSE_CYC cycles in this state.
  - force_relock is ignored here.
- WAIT_LOCK: pll_rst=0, core_rst=1.
  - locked_s=1 → FILTER.
  - The timeout timer is a separate CNT_W counter. It clears on entry from RESET_PLL and runs through WAIT_LOCK and FILTER.
- FILTER:
  - locked_s=0 → WAIT_LOCK; the timeout timer keeps running.
  - LOCK_FILT_CYC consecutive cycles with locked_s=1 → HOLD.
- Timeout: if the timer reaches LOCK_TIMEOUT_CYC−1 while in WAIT_LOCK or FILTER → RESET_PLL, and timeout_cnt increments.
  - If FILTER completes on the same cycle, FILTER completion wins and there is no timeout.
- HOLD: core_rst=1.
  - locked_s=0 → RESET_PLL, and relock_cnt increments.
  - After HOLD_CYC cycles → RUN.
- RUN: core_rst=0, pll_ready=1.
  - locked_s=0 → RESET_PLL, and relock_cnt increments.
- force_relock=1 in any state except RESET_PLL → RESET_PLL. No counter increments.
  - force_relock has priority over every other transition on that cycle.
- Both event counters saturate at 255; they do not wrap.

## Timing
- After rst deasserts, pll_rst falls on the RST_PULSE_CYC-th refclk rising edge.
- Lock acceptance: number the first edge that samples locked=1 as edge 1. pll_ready rises and core_rst falls on edge LOCK_FILT_CYC+HOLD_CYC+3, which is edge 323 with defaults.
  - This requires locked to stay high throughout and the timeout not to be hit.
- Lock loss in HOLD/RUN: number the first edge that samples locked=0 as edge 1. On edge 3:
  - pll_rst=1, core_rst=1, pll_ready=0;
  - relock_cnt has its new value.
- force_relock sampled high at edge N → pll_rst=1 and core_rst=1 after edge N.
- A locked glitch shorter than LOCK_FILT_CYC cycles during FILTER never reaches HOLD.
- rst asserted mid-operation returns every output to its reset value immediately (asynchronous), including both counters.

## Test plan
- Release rst with locked=0 → pll_rst high for exactly 16 edges; core_rst=1, pll_ready=0.
- Raise locked 100 cycles after pll_rst falls and hold it high → pll_ready rises on edge 323 after the first edge sampling locked=1; core_rst falls on the same edge; counters stay 0.
- In FILTER, pulse locked low for 1 cycle at filter count 40 → state returns to WAIT_LOCK; ready is delayed by the full refilter; no counter changes.
- Keep locked=0 → RESET_PLL re-entered every 16+50000 cycles; timeout_cnt increments by 1 per retry. Force timeout_cnt to 255, then one more timeout → it stays 255.
- In RUN, drop locked → pll_rst/core_rst high and pll_ready low on edge 3; relock_cnt=1. Relock → pll_ready returns after another 323 edges.
- Assert force_relock in RUN and rst mid-HOLD → RESET_PLL with no count change for force_relock. rst asynchronously clears all outputs to reset values.
